alu4_seq_ctrl: RTL and testbench

Command-side master for the 4-bit flag-producing ALU. It accepts one multiply or divide command and drives the ALU's a/b/select inputs. It consumes the ALU's res/cf/zf/sf outputs and iterates repeated add (multiply) or repeated subtract (divide) until done. It sits between the datapath control logic and the alu4 instance; the ALU itself is external.

---
 rtl/alu4_seq_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_alu4_seq_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu4_seq_ctrl.sv
// Sequencing master for an external registered 4-bit ALU: multiply by repeated add, divide by repeated subtract.
// Optional single-shot AND/OR commands (op=10/11) are enabled by defining ALU_SEQ_LOGIC_EN.
module alu4_seq_ctrl #(
  parameter int W       = 4,
  parameter int ALU_LAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [W-1:0] opa,
  input  logic [W-1:0] opb,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic [W-1:0] remainder,
  output logic         err,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [1:0]   alu_sel,
  input  logic [W-1:0] alu_res,
  input  logic         alu_cf,
  input  logic         alu_zf,
  input  logic         alu_sf
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_EVAL  = 3'd3;
  localparam logic [2:0] S_FIN   = 3'd4;

  localparam logic [1:0] OP_MUL = 2'b00;
  localparam logic [1:0] OP_DIV = 2'b01;
  localparam logic [1:0] SEL_ADD = 2'b00;
  localparam logic [1:0] SEL_SUB = 2'b01;

  localparam int WCW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [WCW-1:0] WLAST = WCW'(ALU_LAT - 1);

  logic [2:0]     state;
  logic [WCW-1:0] wcnt;
  logic [1:0]     op_r;
  logic [W-1:0]   opa_r;
  logic [W-1:0]   opb_r;
  logic [W-1:0]   acc;    // running product, or running remainder for divide
  logic [W-1:0]   q;
  logic [W-1:0]   cnt;
  logic           ovf;

  assign ready = (state == S_IDLE);
  assign busy  = ~ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      wcnt      <= '0;
      op_r      <= '0;
      opa_r     <= '0;
      opb_r     <= '0;
      acc       <= '0;
      q         <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      remainder <= '0;
      err       <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_sel   <= SEL_ADD;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            op_r  <= op;
            opa_r <= opa;
            opb_r <= opb;
            ovf   <= 1'b0;
            q     <= '0;
            cnt   <= opb;
            case (op)
              OP_MUL: begin
                acc   <= '0;
                state <= (opb == '0) ? S_FIN : S_ISSUE;
              end
              OP_DIV: begin
                acc   <= opa;
                state <= (opb == '0) ? S_FIN : S_ISSUE;
              end
              default: begin
                acc <= '0;
`ifdef ALU_SEQ_LOGIC_EN
                state <= S_ISSUE;
`else
                state <= S_FIN;
`endif
              end
            endcase
          end
        end

        S_ISSUE: begin
          wcnt  <= '0;
          state <= S_WAIT;
          case (op_r)
            OP_MUL: begin
              alu_a   <= acc;
              alu_b   <= opa_r;
              alu_sel <= SEL_ADD;
            end
            OP_DIV: begin
              alu_a   <= acc;
              alu_b   <= opb_r;
              alu_sel <= SEL_SUB;
            end
            default: begin
`ifdef ALU_SEQ_LOGIC_EN
              alu_a   <= opa_r;
              alu_b   <= opb_r;
              alu_sel <= op_r;
`endif
            end
          endcase
        end

        // ALU flags are only trusted on the edge that leaves EVAL
        S_WAIT: begin
          if (wcnt == WLAST) state <= S_EVAL;
          else               wcnt  <= wcnt + 1'b1;
        end

        S_EVAL: begin
          case (op_r)
            OP_MUL: begin
              acc   <= alu_res;
              ovf   <= ovf | alu_cf;
              cnt   <= cnt - 1'b1;
              state <= (cnt == W'(1)) ? S_FIN : S_ISSUE;
            end
            OP_DIV: begin
              if (alu_sf) begin
                state <= S_FIN;
              end else if (alu_zf) begin
                q     <= q + 1'b1;
                acc   <= '0;
                state <= S_FIN;
              end else begin
                q     <= q + 1'b1;
                acc   <= alu_res;
                state <= S_ISSUE;
              end
            end
            default: begin
              acc   <= alu_res;
              state <= S_FIN;
            end
          endcase
        end

        S_FIN: begin
          done  <= 1'b1;
          state <= S_IDLE;
          case (op_r)
            OP_MUL: begin
              result    <= acc;
              remainder <= '0;
              err       <= ovf;
            end
            OP_DIV: begin
              if (opb_r == '0) begin
                result    <= '1;
                remainder <= opa_r;
                err       <= 1'b1;
              end else begin
                result    <= q;
                remainder <= acc;
                err       <= 1'b0;
              end
            end
            default: begin
`ifdef ALU_SEQ_LOGIC_EN
              result    <= acc;
              remainder <= '0;
              err       <= 1'b0;
`else
              result    <= '0;
              remainder <= '0;
              err       <= 1'b1;
`endif
            end
          endcase
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu4_seq_ctrl.sv
// Self-checking bench for alu4_seq_ctrl with a behavioural registered ALU attached.
module tb_alu4_seq_ctrl;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] opa, opb;
  logic         ready, busy, done, err;
  logic [W-1:0] result, remainder;
  logic [W-1:0] alu_a, alu_b, alu_res;
  logic [1:0]   alu_sel;
  logic         alu_cf, alu_zf, alu_sf;

  int tests_run = 0;
  int fails     = 0;

  always #5 clk = ~clk;

  alu4_seq_ctrl #(.W(W), .ALU_LAT(1)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .opa(opa), .opb(opb),
    .ready(ready), .busy(busy), .done(done), .result(result),
    .remainder(remainder), .err(err), .alu_a(alu_a), .alu_b(alu_b),
    .alu_sel(alu_sel), .alu_res(alu_res), .alu_cf(alu_cf), .alu_zf(alu_zf),
    .alu_sf(alu_sf)
  );

  // External ALU model: one register stage between operands and res/flags
  logic [W-1:0] m_res;
  logic         m_cf, m_sf, m_zf;
  always_comb begin
    m_res = '0;
    m_cf  = 1'b0;
    m_sf  = 1'b0;
    case (alu_sel)
      2'b00: {m_cf, m_res} = {1'b0, alu_a} + {1'b0, alu_b};
      2'b01: begin
        if (alu_a < alu_b) begin
          m_res = alu_b - alu_a;
          m_sf  = 1'b1;
        end else begin
          m_res = alu_a - alu_b;
        end
      end
      2'b10: m_res = alu_a & alu_b;
      default: m_res = alu_a | alu_b;
    endcase
    m_zf = (m_res == '0);
  end

  always @(posedge clk) begin
    alu_res <= m_res;
    alu_cf  <= m_cf;
    alu_sf  <= m_sf;
    alu_zf  <= m_zf;
  end

  // Reference: results straight from arithmetic, latency from iteration count
  task automatic model(input logic [1:0] o, input logic [W-1:0] a, b,
                       output logic [W-1:0] r, rm, output logic e, output int lat);
    int p, iters;
    case (o)
      2'b00: begin
        p = int'(a) * int'(b);
        r = W'(p % 16); rm = '0; e = (p > 15);
        lat = 2 + 3 * int'(b);
      end
      2'b01: begin
        if (b == 0) begin
          r = '1; rm = a; e = 1'b1; lat = 2;
        end else begin
          r = a / b; rm = a % b; e = 1'b0;
          iters = (a != 0 && (a % b) == 0) ? int'(a / b) : int'(a / b) + 1;
          lat = 2 + 3 * iters;
        end
      end
      default: begin
`ifdef ALU_SEQ_LOGIC_EN
        r = (o == 2'b10) ? (a & b) : (a | b); rm = '0; e = 1'b0; lat = 5;
`else
        r = '0; rm = '0; e = 1'b1; lat = 2;
`endif
      end
    endcase
  endtask

  // Issue one command and wait (bounded) for done; lat counts from the start cycle
  task automatic run_cmd(input logic [1:0] o, input logic [W-1:0] a, b,
                         output logic [W-1:0] r, rm, output logic e,
                         output int lat, output logic [3:0] selm);
    @(negedge clk);
    start = 1'b1; op = o; opa = a; opb = b;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    selm = '0;
    while (!done && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      if (busy && lat >= 3) selm[alu_sel] = 1'b1;
    end
    r = result; rm = remainder; e = err;
  endtask

  task automatic check_cmd(input string name, input logic [1:0] o, input logic [W-1:0] a, b);
    logic [W-1:0] r, rm, er, erm;
    logic e, ee;
    int lat, elat;
    logic [3:0] selm;
    model(o, a, b, er, erm, ee, elat);
    run_cmd(o, a, b, r, rm, e, lat, selm);
    tests_run++;
    if ({r, rm, e} !== {er, erm, ee}) begin
      fails++;
      $display("FAIL %s op=%0d a=%0d b=%0d: got res=%0d rem=%0d err=%0b, want res=%0d rem=%0d err=%0b",
               name, o, a, b, r, rm, e, er, erm, ee);
    end
    tests_run++;
    if (lat !== elat) begin
      fails++;
      $display("FAIL %s_latency op=%0d a=%0d b=%0d: got %0d want %0d", name, o, a, b, lat, elat);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; op = '0; opa = '0; opb = '0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if ({ready, busy, done, result, remainder, err, alu_a, alu_b, alu_sel} !==
        {1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0, 2'b00}) begin
      fails++;
      $display("FAIL reset_state: got rdy=%b busy=%b done=%b res=%0d rem=%0d err=%b a=%0d b=%0d sel=%0d, want rdy=1 rest 0",
               ready, busy, done, result, remainder, err, alu_a, alu_b, alu_sel);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_multiply();
    logic [W-1:0] r, rm; logic e; int lat; logic [3:0] selm;
    run_cmd(2'b00, 4'd3, 4'd5, r, rm, e, lat, selm);
    tests_run++;
    if ({r, rm, e} !== {4'd15, 4'd0, 1'b0} || lat !== 17) begin
      fails++;
      $display("FAIL mul_3x5: got res=%0d rem=%0d err=%b lat=%0d, want 15 0 0 lat=17", r, rm, e, lat);
    end
    tests_run++;
    if (selm !== 4'b0001) begin
      fails++;
      $display("FAIL mul_sel: got select mask %b want 0001", selm);
    end
    check_cmd("mul_5x4", 2'b00, 4'd5, 4'd4);
    check_cmd("mul_15x15", 2'b00, 4'd15, 4'd15);
    check_cmd("mul_0x7", 2'b00, 4'd0, 4'd7);
  endtask

  task automatic test_divide();
    check_cmd("div_13_4", 2'b01, 4'd13, 4'd4);
    tests_run++;
    if ({alu_a, alu_b, alu_sel, alu_sf} !== {4'd1, 4'd4, 2'b01, 1'b1}) begin
      fails++;
      $display("FAIL div_last_sub: got a=%0d b=%0d sel=%0d sf=%b want a=1 b=4 sel=1 sf=1",
               alu_a, alu_b, alu_sel, alu_sf);
    end
    check_cmd("div_8_2", 2'b01, 4'd8, 4'd2);
    check_cmd("div_15_1", 2'b01, 4'd15, 4'd1);
    check_cmd("div_3_9", 2'b01, 4'd3, 4'd9);
    check_cmd("div_0_5", 2'b01, 4'd0, 4'd5);
  endtask

  task automatic test_no_alu_cases();
    logic [9:0] snap;
    snap = {alu_a, alu_b, alu_sel};
    check_cmd("div_7_0", 2'b01, 4'd7, 4'd0);
    check_cmd("mul_9x0", 2'b00, 4'd9, 4'd0);
    tests_run++;
    if ({alu_a, alu_b, alu_sel} !== snap) begin
      fails++;
      $display("FAIL no_alu_txn: alu bus %h changed, want %h", {alu_a, alu_b, alu_sel}, snap);
    end
  endtask

  task automatic test_logic_ops();
    logic [9:0] snap;
    snap = {alu_a, alu_b, alu_sel};
    check_cmd("and_c_a", 2'b10, 4'hC, 4'hA);
`ifdef ALU_SEQ_LOGIC_EN
    tests_run++;
    if (alu_sel !== 2'b10) begin
      fails++;
      $display("FAIL and_sel: got %0d want 2", alu_sel);
    end
`else
    tests_run++;
    if ({alu_a, alu_b, alu_sel} !== snap) begin
      fails++;
      $display("FAIL logic_no_alu: alu bus %h changed, want %h", {alu_a, alu_b, alu_sel}, snap);
    end
`endif
    check_cmd("or_c_a", 2'b11, 4'hC, 4'hA);
  endtask

  task automatic test_back_to_back();
    int n;
    @(negedge clk);
    start = 1'b1; op = 2'b00; opa = 4'd3; opb = 4'd5;
    @(posedge clk); #1;
    start = 1'b0;
    n = 1;
    while (!done && n < 200) begin
      if (n == 4) begin
        start = 1'b1; op = 2'b01; opa = 4'd15; opb = 4'd1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      n++;
    end
    tests_run++;
    if ({result, remainder, err, ready} !== {4'd15, 4'd0, 1'b0, 1'b1} || n !== 17) begin
      fails++;
      $display("FAIL b2b_first: got res=%0d rem=%0d err=%b rdy=%b lat=%0d, want 15 0 0 1 lat=17",
               result, remainder, err, ready, n);
    end
    // next run_cmd raises start on the negedge of the done cycle
    check_cmd("b2b_second", 2'b01, 4'd13, 4'd4);
  endtask

  task automatic test_reset_mid_divide();
    int dones;
    @(negedge clk);
    start = 1'b1; op = 2'b01; opa = 4'd15; opb = 4'd1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if ({ready, busy, done, result, remainder, err, alu_a, alu_b, alu_sel} !==
        {1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0, 2'b00}) begin
      fails++;
      $display("FAIL rst_mid_div: got rdy=%b busy=%b done=%b res=%0d rem=%0d err=%b a=%0d b=%0d sel=%0d, want rdy=1 rest 0",
               ready, busy, done, result, remainder, err, alu_a, alu_b, alu_sel);
    end
    @(negedge clk); rst = 1'b0;
    dones = 0;
    repeat (60) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    tests_run++;
    if (dones !== 0 || result !== 4'd0) begin
      fails++;
      $display("FAIL rst_no_done: got %0d done pulses res=%0d, want 0 pulses res=0", dones, result);
    end
    check_cmd("after_rst", 2'b00, 4'd2, 4'd7);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      check_cmd("rand", 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                4'($urandom_range(0, 15)));
    end
  endtask

  initial begin
    test_reset();
    test_multiply();
    test_divide();
    test_no_alu_cases();
    test_logic_ops();
    test_back_to_back();
    test_reset_mid_divide();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
